// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the shared BRAM line port: data has priority, a bounded streak
// guard keeps instruction requests from starving, and a timeout returns a poison line.
module mem_port_arbiter #(
   parameter int unsigned ADDR_BITS       = 16,
   parameter int unsigned LINE_BITS       = 128,
   parameter int unsigned DATA_STREAK_MAX = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 i_req,
   input  logic                 i_write,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [LINE_BITS-1:0] i_wdata,
   output logic [LINE_BITS-1:0] i_rdata,
   output logic                 i_valid,
   output logic                 i_err,
   input  logic                 d_req,
   input  logic                 d_write,
   input  logic [ADDR_BITS-1:0] d_addr,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 d_valid,
   output logic                 d_err,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [LINE_BITS-1:0] mem_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata,
   input  logic                 mem_valid
);

   localparam int unsigned SW = $clog2(DATA_STREAK_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LINE_BITS-1:0] ERR_LINE = {LINE_BITS/32{32'hDEADBEEF}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {INST, DATA} owner_t;

   state_t               state_q;
   owner_t               owner_q;
   logic [SW-1:0]        streak_q;
   logic [TW-1:0]        tmo_q;
   logic                 mem_req_q, mem_write_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic [LINE_BITS-1:0] mem_wdata_q;
   logic [LINE_BITS-1:0] i_rdata_q, d_rdata_q;
   logic                 i_valid_q, i_err_q, d_valid_q, d_err_q;
   logic                 grant_inst;
   logic [LINE_BITS-1:0] resp_line;

   always_comb begin
      grant_inst = 1'b0;
      if (i_req && !d_req)
         grant_inst = 1'b1;
      else if (i_req && d_req && (streak_q == STREAK_MAX))
         grant_inst = 1'b1;
   end

   // A real response wins over a timeout landing in the same cycle.
   assign resp_line = mem_valid ? mem_rdata : ERR_LINE;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         owner_q     <= DATA;
         streak_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_valid_q   <= 1'b0;
         i_err_q     <= 1'b0;
         d_valid_q   <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         i_valid_q <= 1'b0;
         i_err_q   <= 1'b0;
         d_valid_q <= 1'b0;
         d_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  state_q   <= BUSY;
                  mem_req_q <= 1'b1;
                  tmo_q     <= '0;
                  if (grant_inst) begin
                     owner_q     <= INST;
                     mem_write_q <= i_write;
                     mem_addr_q  <= i_addr;
                     mem_wdata_q <= i_wdata;
                     streak_q    <= '0;
                  end else begin
                     owner_q     <= DATA;
                     mem_write_q <= d_write;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     if (!i_req)
                        streak_q <= '0;
                     else if (streak_q != STREAK_MAX)
                        streak_q <= streak_q + 1'b1;
                  end
               end
            end
            BUSY: begin
               if (mem_valid || (tmo_q == TMO_LAST)) begin
                  state_q   <= DONE;
                  mem_req_q <= 1'b0;
                  if (owner_q == INST) begin
                     i_rdata_q <= resp_line;
                     i_valid_q <= 1'b1;
                     i_err_q   <= ~mem_valid;
                  end else begin
                     d_rdata_q <= resp_line;
                     d_valid_q <= 1'b1;
                     d_err_q   <= ~mem_valid;
                  end
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_valid   = i_valid_q;
   assign i_err     = i_err_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int unsigned AB   = 16;
   localparam int unsigned LB   = 128;
   localparam int unsigned SMAX = 4;
   localparam int unsigned TMO  = 255;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          i_req, i_write, d_req, d_write, mem_valid;
   logic [AB-1:0] i_addr, d_addr;
   logic [LB-1:0] i_wdata, d_wdata, mem_rdata;
   logic [LB-1:0] i_rdata, d_rdata, mem_wdata;
   logic          i_valid, i_err, d_valid, d_err, mem_req, mem_write;
   logic [AB-1:0] mem_addr;

   always #5 HCLK = ~HCLK;

   mem_port_arbiter #(
      .ADDR_BITS(AB), .LINE_BITS(LB), .DATA_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;
   logic [LB-1:0] exp_i_rd, exp_d_rd;
   logic [LB-1:0] poison;

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [LB-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_i(input logic wr, input logic [AB-1:0] a, input logic [LB-1:0] w);
      i_write = wr; i_addr = a; i_wdata = w; i_req = 1'b1;
   endtask

   task automatic set_d(input logic wr, input logic [AB-1:0] a, input logic [LB-1:0] w);
      d_write = wr; d_addr = a; d_wdata = w; d_req = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_ctl"}, {mem_req, mem_write, i_valid, i_err, d_valid, d_err}, '0);
      chk({tag, "_mem_addr"}, mem_addr, '0);
      chk({tag, "_mem_wdata"}, mem_wdata, '0);
      chk({tag, "_i_rdata"}, i_rdata, '0);
      chk({tag, "_d_rdata"}, d_rdata, '0);
   endtask

   // Called just after the granting edge; answers after lat cycles with rd.
   task automatic serve(input int unsigned lat, input bit exp_inst, input logic [LB-1:0] rd);
      logic [AB-1:0] ea;
      logic [LB-1:0] ew;
      logic          ewr;
      ea  = exp_inst ? i_addr  : d_addr;
      ew  = exp_inst ? i_wdata : d_wdata;
      ewr = exp_inst ? i_write : d_write;
      chk("grant_mem_req", mem_req, 1'b1);
      chk(exp_inst ? "grant_addr_inst" : "grant_addr_data", mem_addr, ea);
      chk("grant_write", mem_write, ewr);
      chk("grant_wdata", mem_wdata, ew);
      for (int unsigned c = 1; c < lat; c++) begin
         mem_valid = 1'b0;
         step();
         chk("busy_mem_req", mem_req, 1'b1);
         chk("busy_wdata_stable", mem_wdata, ew);
         chk("busy_no_valid", {i_valid, d_valid, i_err, d_err}, '0);
      end
      mem_valid = 1'b1;
      mem_rdata = rd;
      step();
      mem_valid = 1'b0;
      mem_rdata = rnd_line();
      if (exp_inst) exp_i_rd = rd; else exp_d_rd = rd;
      chk("done_flags", {i_valid, d_valid, i_err, d_err}, exp_inst ? 4'b1000 : 4'b0100);
      chk("done_i_rdata", i_rdata, exp_i_rd);
      chk("done_d_rdata", d_rdata, exp_d_rd);
      chk("done_mem_req", mem_req, 1'b0);
      if (exp_inst) i_req = 1'b0; else d_req = 1'b0;
      step();
      chk("idle_flags", {i_valid, d_valid, i_err, d_err, mem_req}, '0);
   endtask

   initial begin
      bit          exp_inst, pi, pd;
      int unsigned wc;

      poison    = {4{32'hDEADBEEF}};
      HRESETn   = 1'b0;
      i_req = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
      d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      mem_valid = 1'b0; mem_rdata = '0;
      exp_i_rd  = '0; exp_d_rd = '0;
      #2;
      chk_all_zero("reset");
      @(negedge HCLK);
      HRESETn = 1'b1;
      step();

      // Single data read at 0x0040, one-cycle memory latency, then back-to-back.
      set_d(1'b0, 16'h0040, rnd_line());
      step();
      serve(1, 1'b0, rnd_line());
      set_d(1'b0, 16'h0041, rnd_line());
      step();
      serve(1, 1'b0, rnd_line());

      // Both clients requesting continuously: every fifth grant goes to INST.
      set_i(1'b0, AB'($urandom), rnd_line());
      set_d($urandom_range(0, 1), AB'($urandom), rnd_line());
      step();
      for (int unsigned g = 0; g < 10; g++) begin
         exp_inst = ((g % (SMAX + 1)) == SMAX);
         serve($urandom_range(1, 3), exp_inst, rnd_line());
         if (exp_inst) set_i($urandom_range(0, 1), AB'($urandom), rnd_line());
         else          set_d($urandom_range(0, 1), AB'($urandom), rnd_line());
         if (g == 9) begin
            i_req = 1'b0; d_req = 1'b0;
         end else begin
            step();
         end
      end
      step();
      chk("streak_end_idle", mem_req, 1'b0);

      // Instruction write in flight while the data client starts requesting.
      set_i(1'b1, 16'h1234, 128'h0123456789ABCDEF0123456789ABCDEF);
      step();
      set_d(1'b0, 16'h5678, rnd_line());
      serve(4, 1'b1, rnd_line());
      step();
      serve(2, 1'b0, rnd_line());

      // Memory never answers: timeout returns the poison line with err.
      set_d(1'b0, 16'h0BAD, rnd_line());
      step();
      chk("tmo_mem_req", mem_req, 1'b1);
      for (int unsigned c = 1; c < TMO; c++) begin
         step();
         chk("tmo_busy", {mem_req, d_valid, d_err}, 3'b100);
      end
      step();
      chk("tmo_flags", {i_valid, d_valid, i_err, d_err}, 4'b0101);
      chk("tmo_d_rdata", d_rdata, poison);
      chk("tmo_i_rdata", i_rdata, exp_i_rd);
      chk("tmo_mem_req_low", mem_req, 1'b0);
      exp_d_rd = poison;
      d_req = 1'b0;
      step();
      chk("tmo_idle", {i_valid, d_valid, i_err, d_err, mem_req}, '0);

      // mem_valid while idle is ignored.
      mem_valid = 1'b1;
      mem_rdata = rnd_line();
      for (int unsigned c = 0; c < 2; c++) begin
         step();
         chk("idle_strobe_flags", {i_valid, d_valid, i_err, d_err, mem_req}, '0);
         chk("idle_strobe_i_rdata", i_rdata, exp_i_rd);
         chk("idle_strobe_d_rdata", d_rdata, exp_d_rd);
      end
      mem_valid = 1'b0;
      set_d(1'b1, AB'($urandom), rnd_line());
      step();
      serve(1, 1'b0, rnd_line());

      // Reset in the middle of BUSY, with a late memory response.
      set_i(1'b0, 16'h00C0, rnd_line());
      step();
      step();
      step();
      chk("pre_reset_busy", mem_req, 1'b1);
      HRESETn = 1'b0;
      #1;
      chk_all_zero("async_reset");
      i_req     = 1'b0;
      mem_valid = 1'b1;
      step();
      chk_all_zero("held_reset");
      HRESETn = 1'b1;
      exp_i_rd = '0;
      exp_d_rd = '0;
      for (int unsigned c = 0; c < 3; c++) begin
         step();
         mem_valid = 1'b0;
         chk("post_reset_quiet", {i_valid, d_valid, i_err, d_err, mem_req}, '0);
      end
      set_d(1'b0, AB'($urandom), rnd_line());
      step();
      serve(1, 1'b0, rnd_line());

      // Random mix of requests; grant follows priority plus streak guard.
      wc = 0; pi = 1'b0; pd = 1'b0;
      repeat (24) begin
         if (!pi && $urandom_range(0, 1) == 1) begin
            set_i($urandom_range(0, 1), AB'($urandom), rnd_line()); pi = 1'b1;
         end
         if (!pd && $urandom_range(0, 1) == 1) begin
            set_d($urandom_range(0, 1), AB'($urandom), rnd_line()); pd = 1'b1;
         end
         if (!pi && !pd) begin
            set_d($urandom_range(0, 1), AB'($urandom), rnd_line()); pd = 1'b1;
         end
         exp_inst = (pi && pd) ? (wc == SMAX) : pi;
         if (exp_inst)  wc = 0;
         else if (pi)   wc = (wc == SMAX) ? wc : wc + 1;
         else           wc = 0;
         step();
         serve($urandom_range(1, 4), exp_inst, rnd_line());
         if (exp_inst) pi = 1'b0; else pd = 1'b0;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      step();
      chk("final_idle", mem_req, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
